// File: rtl/alu_div_seq_if.sv
// Request/result handshake bundle between the execute stage and alu_div_seq.
// Signal names are seen from the divider side; the master modport drives the requests.
interface alu_div_seq_if #(
   parameter int unsigned DATA_WIDTH = 32
) ();
   logic                  valid_i;
   logic                  ready_o;
   logic [1:0]            op_i;
   logic [DATA_WIDTH-1:0] a_i;
   logic [DATA_WIDTH-1:0] b_i;
   logic                  flush_i;
   logic                  valid_o;
   logic                  ready_i;
   logic [DATA_WIDTH-1:0] res_o;
   logic                  busy_o;
   logic                  div_zero_o;

   modport slave (
      input  valid_i, op_i, a_i, b_i, flush_i, ready_i,
      output ready_o, valid_o, res_o, busy_o, div_zero_o
   );

   modport master (
      output valid_i, op_i, a_i, b_i, flush_i, ready_i,
      input  ready_o, valid_o, res_o, busy_o, div_zero_o
   );
endinterface

// File: rtl/alu_div_seq.sv
// RV32M div/divu/rem/remu sequencer: radix-2 restoring divider, one quotient bit per cycle.
// Optional macro ALU_DIV_EARLY_OUT_EN finishes |a| < |b| requests in one edge.
module alu_div_seq #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input logic         clk_i,
   input logic         rst_ni,
   alu_div_seq_if.slave bus
);

   localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;

   typedef enum logic [1:0] {StIdle, StCalc, StFixup, StDone} state_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] rem_q, rem_d;
   logic [DATA_WIDTH-1:0] quo_q, quo_d;
   logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
   logic                  neg_quo_q, neg_quo_d;
   logic                  neg_rem_q, neg_rem_d;
   logic                  sel_rem_q, sel_rem_d;
   logic [DATA_WIDTH-1:0] res_q, res_d;
   logic                  dz_q, dz_d;

   logic                  signed_op;
   logic                  a_neg, b_neg;
   logic [DATA_WIDTH-1:0] a_mag, b_mag;
   logic                  ovf;
   logic [DATA_WIDTH:0]   shifted;
   logic [DATA_WIDTH-1:0] diff;
   logic                  take;
   logic [DATA_WIDTH-1:0] quo_fix, rem_fix;

   always_comb begin
      signed_op = ~bus.op_i[0];
      a_neg     = signed_op & bus.a_i[DATA_WIDTH-1];
      b_neg     = signed_op & bus.b_i[DATA_WIDTH-1];
      a_mag     = a_neg ? -bus.a_i : bus.a_i;
      b_mag     = b_neg ? -bus.b_i : bus.b_i;
      ovf       = signed_op && (bus.a_i == {1'b1, {(DATA_WIDTH-1){1'b0}}}) && (&bus.b_i);
      // Shifted partial remainder carries one extra bit so the compare stays unsigned.
      shifted   = {rem_q, quo_q[DATA_WIDTH-1]};
      take      = shifted >= {1'b0, dvs_q};
      diff      = shifted[DATA_WIDTH-1:0] - dvs_q;
      quo_fix   = neg_quo_q ? -quo_q : quo_q;
      rem_fix   = neg_rem_q ? -rem_q : rem_q;
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      sel_rem_d = sel_rem_q;
      res_d     = res_q;
      dz_d      = dz_q;

      unique case (state_q)
         StIdle: begin
            if (bus.valid_i) begin
               sel_rem_d = bus.op_i[1];
               neg_quo_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               dz_d      = 1'b0;
               if (bus.b_i == '0) begin
                  res_d   = bus.op_i[1] ? bus.a_i : '1;
                  dz_d    = 1'b1;
                  state_d = StDone;
               end else if (ovf) begin
                  res_d   = bus.op_i[1] ? '0 : bus.a_i;
                  state_d = StDone;
`ifdef ALU_DIV_EARLY_OUT_EN
               end else if (a_mag < b_mag) begin
                  res_d   = bus.op_i[1] ? bus.a_i : '0;
                  state_d = StDone;
`endif
               end else begin
                  rem_d   = '0;
                  quo_d   = a_mag;
                  dvs_d   = b_mag;
                  cnt_d   = CW'(DATA_WIDTH);
                  state_d = StCalc;
               end
            end
         end
         StCalc: begin
            rem_d = take ? diff : shifted[DATA_WIDTH-1:0];
            quo_d = {quo_q[DATA_WIDTH-2:0], take};
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = StFixup;
         end
         StFixup: begin
            res_d   = sel_rem_q ? rem_fix : quo_fix;
            state_d = StDone;
         end
         StDone: begin
            if (bus.ready_i) begin
               dz_d    = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // A flush overrides whatever the state logic decided, including acceptance in idle.
      if (bus.flush_i) begin
         state_d = StIdle;
         dz_d    = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         sel_rem_q <= 1'b0;
         res_q     <= '0;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         sel_rem_q <= sel_rem_d;
         res_q     <= res_d;
         dz_q      <= dz_d;
      end
   end

   always_comb begin
      bus.ready_o    = (state_q == StIdle);
      bus.busy_o     = (state_q != StIdle);
      bus.valid_o    = (state_q == StDone);
      bus.res_o      = res_q;
      bus.div_zero_o = dz_q;
   end

endmodule

// File: tb/tb_alu_div_seq.sv
// Self-checking bench for alu_div_seq: directed cases from the RV32M rules plus random operands
// compared against an arithmetic reference model.
module tb_alu_div_seq;

   localparam int unsigned W = 32;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   alu_div_seq_if #(.DATA_WIDTH(W)) bus ();

   alu_div_seq #(.DATA_WIDTH(W)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      int sa;
      int sb;
      sa = $signed(a);
      sb = $signed(b);
      if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
      if (!op[0]) return op[1] ? sa % sb : sa / sb;
      return op[1] ? a % b : a / b;
   endfunction

   function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
      longint ma;
      longint mb;
      if (b == 32'h0) return 1;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      ma = op[0] ? longint'({32'h0, a}) : longint'($signed(a));
      mb = op[0] ? longint'({32'h0, b}) : longint'($signed(b));
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
`ifdef ALU_DIV_EARLY_OUT_EN
      if (ma < mb) return 1;
`endif
      return W + 2;
   endfunction

   // Issue one request, measure latency, optionally hold backpressure, then consume.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
      logic [31:0] exp_res;
      int          lat;
      exp_res = ref_res(op, a, b);
      @(negedge clk);
      chk("ready_idle", bus.ready_o, 1);
      bus.valid_i = 1'b1;
      bus.op_i    = op;
      bus.a_i     = a;
      bus.b_i     = b;
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
      bus.a_i     = $urandom;
      bus.b_i     = $urandom;
      bus.op_i    = 2'($urandom);
      lat = 1;
      while (!bus.valid_o && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk($sformatf("lat op%0d a%0h b%0h", op, a, b), lat, ref_lat(op, a, b));
      chk($sformatf("res op%0d a%0h b%0h", op, a, b), bus.res_o, exp_res);
      chk("div_zero", bus.div_zero_o, (b == 32'h0));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         bus.valid_i = 1'b1;
         @(posedge clk);
         #1;
         chk("bp_valid", bus.valid_o, 1);
         chk("bp_ready", bus.ready_o, 0);
         chk("bp_res", bus.res_o, exp_res);
      end
      @(negedge clk);
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b1;
      @(posedge clk);
      #1;
      bus.ready_i = 1'b0;
      chk("consumed_valid", bus.valid_o, 0);
      chk("consumed_ready", bus.ready_o, 1);
      chk("consumed_busy", bus.busy_o, 0);
      chk("consumed_dz", bus.div_zero_o, 0);
      chk("consumed_res_kept", bus.res_o, exp_res);
   endtask

   initial begin
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      int          vhits;
      checks      = 0;
      failures    = 0;
      rst_n       = 1'b0;
      bus.valid_i = 1'b0;
      bus.op_i    = 2'b00;
      bus.a_i     = '0;
      bus.b_i     = '0;
      bus.flush_i = 1'b0;
      bus.ready_i = 1'b0;
      #12;
      chk("rst_valid", bus.valid_o, 0);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_dz", bus.div_zero_o, 0);
      chk("rst_res", bus.res_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_ready", bus.ready_o, 1);

      run_op(2'b01, 32'd100, 32'd7, 0);
      run_op(2'b11, 32'd100, 32'd7, 0);
      run_op(2'b00, 32'hFFFF_FF9C, 32'd7, 0);
      run_op(2'b10, 32'hFFFF_FF9C, 32'd7, 0);
      run_op(2'b00, 32'd123, 32'd0, 0);
      run_op(2'b10, 32'd123, 32'd0, 0);
      run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 5);
      run_op(2'b00, 32'd5, 32'hFFFF_FFF0, 0);

      // Flush in the tenth CALC cycle.
      @(negedge clk);
      bus.valid_i = 1'b1;
      bus.op_i    = 2'b01;
      bus.a_i     = 32'd1000;
      bus.b_i     = 32'd3;
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      chk("pre_flush_busy", bus.busy_o, 1);
      bus.flush_i = 1'b1;
      @(posedge clk);
      #1;
      bus.flush_i = 1'b0;
      chk("flush_ready", bus.ready_o, 1);
      chk("flush_busy", bus.busy_o, 0);
      vhits = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.valid_o) vhits++;
      end
      chk("flush_no_valid", vhits, 0);

      // Flush in idle blocks acceptance.
      @(negedge clk);
      bus.valid_i = 1'b1;
      bus.flush_i = 1'b1;
      bus.b_i     = 32'd0;
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
      bus.flush_i = 1'b0;
      chk("flush_idle_busy", bus.busy_o, 0);

      // Asynchronous reset mid-CALC.
      @(negedge clk);
      bus.valid_i = 1'b1;
      bus.op_i    = 2'b00;
      bus.a_i     = 32'd77777;
      bus.b_i     = 32'd13;
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", bus.busy_o, 0);
      chk("arst_valid", bus.valid_o, 0);
      chk("arst_res", bus.res_o, 0);
      chk("arst_ready", bus.ready_o, 1);
      @(negedge clk);
      rst_n = 1'b1;

      for (int n = 0; n < 30; n++) begin
         rop = 2'($urandom);
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 5))
            0: rb = 32'h0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 300));
            3: begin ra = 32'($urandom_range(0, 50)); rb = 32'($urandom_range(51, 1000)); end
            default: ;
         endcase
         run_op(rop, ra, rb, int'($urandom_range(0, 2)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
